reg_file_16x16: RTL and testbench
=================================

// Module: reg_file_16x16
// PURPOSE
// - 16-entry x 16-bit register file feeding the ALU operand buses (A, B) used by
//   ADD/SUB/RED/PADDSB etc.; sits directly upstream of the ALU in the datapath.
// - Two asynchronous read ports, one synchronous write port with full/low-byte/
//   high-byte write modes (LLB/LHB support). R0 reads as zero.
// - Optional same-cycle write->read bypass so the ALU sees the value being written.
// PARAMETERS
// - DATA_W   16  register width; byte modes split at DATA_W/2 (must be even)
// - ADDR_W   4   register address width; NUM_REGS = 2**ADDR_W
// PORTS
// - clk       in   1        clock; all state changes on rising edge
// - rst       in   1        synchronous reset, active high
// - SrcReg1   in   ADDR_W   read port 1 address (drives ALU A)
// - SrcReg2   in   ADDR_W   read port 2 address (drives ALU B)
// - DstReg    in   ADDR_W   write address
// - WriteReg  in   1        write enable
// - WrMode    in   2        00 full, 01 low byte, 10 high byte, 11 reserved
// - DstData   in   DATA_W   write data; byte modes use DstData[DATA_W/2-1:0]
// - SrcData1  out  DATA_W   read data port 1
// - SrcData2  out  DATA_W   read data port 2
// BEHAVIOUR
// - Reset: on rising clk with rst=1 every register <= 0; a write presented in the
//   same cycle is discarded; rst overrides WriteReg.
// - Write (rst=0, WriteReg=1, DstReg!=0) at rising clk, with L=DATA_W/2:
//   00: R[d] <= DstData
//   01: R[d] <= {R[d][DATA_W-1:L], DstData[L-1:0]}
//   10: R[d] <= {DstData[L-1:0], R[d][L-1:0]}
//   11: no write, register unchanged (reserved, must not corrupt state)
// - DstReg==0: write ignored in all modes; R0 storage stays 0.
// - Read: combinational, zero latency. SrcDataN = 0 when SrcRegN==0, else R[SrcRegN].
// - Both ports may address the same register; both return identical data.
// - Write-effective value WV = merged value defined above (what R[d] will hold).
// - No state machine; sole state is the register array (R0 need not be stored).
// - Reads during rst=1 return current array contents (reset takes effect at the edge).
// CONFIGURATION
// - RF_BYPASS_EN defined: if WriteReg=1, rst=0, DstReg!=0, WrMode!=11 and
//   SrcRegN==DstReg, then SrcDataN = WV in the same cycle (write-before-read),
//   including correct byte merge for modes 01/10. Never bypasses to R0.
// - RF_BYPASS_EN undefined: reads always return pre-edge array contents; the
//   new value is visible from the cycle after the write edge.
// TESTING
// - Reset: preload R1..R15=16'hFFFF, assert rst 1 cycle -> all SrcData reads = 16'h0000.
// - Full write: WriteReg=1,DstReg=5,WrMode=00,DstData=16'hA5C3; next cycle
//   SrcReg1=5 -> 16'hA5C3; SrcReg1=SrcReg2=5 -> both 16'hA5C3.
// - R0: write 16'h1234 to R0 mode 00 -> SrcData1 for SrcReg1=0 stays 16'h0000.
// - Byte modes: R7=16'h1234; mode 01 data 16'h00AB -> 16'h12AB; then mode 10
//   data 16'h00CD -> 16'hCDAB; mode 11 data 16'hFFFF -> stays 16'hCDAB.
// - Bypass: R3=16'h0001; same cycle write R3 16'h7F00 mode 00 with SrcReg2=3 ->
//   SrcData2=16'h7F00 with RF_BYPASS_EN, 16'h0001 without; next cycle 16'h7F00 both.
// - Reset vs write: rst=1 and WriteReg=1,DstReg=9,DstData=16'hBEEF same cycle ->
//   R9 reads 16'h0000 after edge; no bypass of 16'hBEEF to a read of R9 post-edge.

Source files
------------

// File: rtl/reg_file_16x16.sv
// ---------------------------------------------------------------------------
// reg_file_16x16
// 16-entry x 16-bit register file that drives the ALU A/B operand buses.
// Two combinational read ports, one synchronous write port with full,
// low-byte and high-byte write modes (used by LLB/LHB). R0 always reads 0.
//
// Optional feature macro: RF_BYPASS_EN
//   defined   -> a read of the register being written in this cycle returns
//                the merged write value (write-before-read).
//   undefined -> reads return the array contents as they were before the edge.
// ---------------------------------------------------------------------------
module reg_file_16x16 #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] SrcReg1,
   input  logic [ADDR_W-1:0] SrcReg2,
   input  logic [ADDR_W-1:0] DstReg,
   input  logic              WriteReg,
   input  logic [1:0]        WrMode,
   input  logic [DATA_W-1:0] DstData,
   output logic [DATA_W-1:0] SrcData1,
   output logic [DATA_W-1:0] SrcData2
);

   localparam int NUM_REGS = 2 ** ADDR_W;
   localparam int HALF_W   = DATA_W / 2;

   typedef enum logic [1:0] {
      MODE_FULL = 2'b00,
      MODE_LOW  = 2'b01,
      MODE_HIGH = 2'b10,
      MODE_RSVD = 2'b11
   } wr_mode_t;

   logic [DATA_W-1:0] regs [0:NUM_REGS-1];
   logic [DATA_W-1:0] cur_value;
   logic [DATA_W-1:0] wr_value;
   logic              wr_en;

   // A write only lands for a non-zero destination and a defined mode;
   // the reserved mode and R0 leave the array untouched.
   always_comb begin
      wr_en = WriteReg && (DstReg != '0) && (wr_mode_t'(WrMode) != MODE_RSVD);
   end

   // Build the value the destination register will hold after the edge,
   // merging the untouched byte from the current contents in byte modes.
   always_comb begin
      cur_value = regs[DstReg];
      wr_value  = cur_value;
      case (wr_mode_t'(WrMode))
         MODE_FULL: wr_value = DstData;
         MODE_LOW:  wr_value = {cur_value[DATA_W-1:HALF_W], DstData[HALF_W-1:0]};
         MODE_HIGH: wr_value = {DstData[HALF_W-1:0], cur_value[HALF_W-1:0]};
         default:   wr_value = cur_value;
      endcase
   end

   // Register array update: reset clears everything and wins over a write
   // presented in the same cycle; R0 is never written so it stays zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[DstReg] <= wr_value;
      end
   end

`ifdef RF_BYPASS_EN
   logic bypass_ok;

   // Forwarding is only legal when the write will really happen at the edge.
   always_comb begin
      bypass_ok = wr_en && !rst;
   end

   // Read port 1: R0 forced to zero, otherwise forward the pending write
   // value when addresses match, else the stored register.
   always_comb begin
      if (SrcReg1 == '0) begin
         SrcData1 = '0;
      end else if (bypass_ok && (SrcReg1 == DstReg)) begin
         SrcData1 = wr_value;
      end else begin
         SrcData1 = regs[SrcReg1];
      end
   end

   // Read port 2: same selection as port 1 with its own address.
   always_comb begin
      if (SrcReg2 == '0) begin
         SrcData2 = '0;
      end else if (bypass_ok && (SrcReg2 == DstReg)) begin
         SrcData2 = wr_value;
      end else begin
         SrcData2 = regs[SrcReg2];
      end
   end
`else
   // Read port 1: R0 forced to zero, otherwise the stored register.
   always_comb begin
      if (SrcReg1 == '0) begin
         SrcData1 = '0;
      end else begin
         SrcData1 = regs[SrcReg1];
      end
   end

   // Read port 2: same selection as port 1 with its own address.
   always_comb begin
      if (SrcReg2 == '0) begin
         SrcData2 = '0;
      end else begin
         SrcData2 = regs[SrcReg2];
      end
   end
`endif

endmodule

// File: tb/tb_reg_file_16x16.sv
// ---------------------------------------------------------------------------
// tb_reg_file_16x16
// Directed, table-driven bench for reg_file_16x16 plus hand-written
// sequences for reset, same-cycle bypass and reset-versus-write.
// Expected values for the bypass cycle follow RF_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_reg_file_16x16;

   logic        clk;
   logic        rst;
   logic [3:0]  SrcReg1;
   logic [3:0]  SrcReg2;
   logic [3:0]  DstReg;
   logic        WriteReg;
   logic [1:0]  WrMode;
   logic [15:0] DstData;
   logic [15:0] SrcData1;
   logic [15:0] SrcData2;

   int num_checks;
   int num_fails;

   typedef struct {
      string       name;
      logic        wr;
      logic [3:0]  dst;
      logic [1:0]  mode;
      logic [15:0] data;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic [15:0] e1;
      logic [15:0] e2;
   } vec_t;

   vec_t vecs[$];

   reg_file_16x16 dut (
      .clk      (clk),
      .rst      (rst),
      .SrcReg1  (SrcReg1),
      .SrcReg2  (SrcReg2),
      .DstReg   (DstReg),
      .WriteReg (WriteReg),
      .WrMode   (WrMode),
      .DstData  (DstData),
      .SrcData1 (SrcData1),
      .SrcData2 (SrcData2)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input logic r, input logic wr, input logic [3:0] dst,
                                input logic [1:0] mode, input logic [15:0] data,
                                input logic [3:0] s1, input logic [3:0] s2);
      rst      = r;
      WriteReg = wr;
      DstReg   = dst;
      WrMode   = mode;
      DstData  = data;
      SrcReg1  = s1;
      SrcReg2  = s2;
      #2;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Advance past the next rising edge; inputs change 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic addVec(input string n, input logic wr, input logic [3:0] dst,
                         input logic [1:0] mode, input logic [15:0] data,
                         input logic [3:0] s1, input logic [3:0] s2,
                         input logic [15:0] e1, input logic [15:0] e2);
      vec_t v;
      v.name = n; v.wr = wr; v.dst = dst; v.mode = mode; v.data = data;
      v.s1 = s1; v.s2 = s2; v.e1 = e1; v.e2 = e2;
      vecs.push_back(v);
   endtask

   initial begin
      logic [15:0] exp_bypass;
      logic [15:0] exp_bypass_lo;
      num_checks = 0;
      num_fails  = 0;

      // Table: each row is one cycle; reads are checked before the edge.
      addVec("full_wr_r5",   1, 4'd5, 2'b00, 16'hA5C3, 4'd1, 4'd2, 16'h0000, 16'h0000);
      addVec("rd_r5_both",   0, 4'd0, 2'b00, 16'h0000, 4'd5, 4'd5, 16'hA5C3, 16'hA5C3);
      addVec("wr_r0_full",   1, 4'd0, 2'b00, 16'h1234, 4'd5, 4'd6, 16'hA5C3, 16'h0000);
      addVec("rd_r0",        0, 4'd0, 2'b00, 16'h0000, 4'd0, 4'd5, 16'h0000, 16'hA5C3);
      addVec("wr_r7_full",   1, 4'd7, 2'b00, 16'h1234, 4'd0, 4'd5, 16'h0000, 16'hA5C3);
      addVec("wr_r7_low",    1, 4'd7, 2'b01, 16'h00AB, 4'd5, 4'd0, 16'hA5C3, 16'h0000);
      addVec("rd_r7_low",    0, 4'd0, 2'b00, 16'h0000, 4'd7, 4'd0, 16'h12AB, 16'h0000);
      addVec("wr_r7_high",   1, 4'd7, 2'b10, 16'h00CD, 4'd5, 4'd0, 16'hA5C3, 16'h0000);
      addVec("rd_r7_high",   0, 4'd0, 2'b00, 16'h0000, 4'd7, 4'd7, 16'hCDAB, 16'hCDAB);
      addVec("wr_r7_rsvd",   1, 4'd7, 2'b11, 16'hFFFF, 4'd7, 4'd5, 16'hCDAB, 16'hA5C3);
      addVec("rd_r7_rsvd",   0, 4'd0, 2'b00, 16'h0000, 4'd7, 4'd0, 16'hCDAB, 16'h0000);
      addVec("wr_r0_low",    1, 4'd0, 2'b01, 16'hFFFF, 4'd0, 4'd0, 16'h0000, 16'h0000);
      addVec("rd_r0_low",    0, 4'd0, 2'b00, 16'h0000, 4'd0, 4'd0, 16'h0000, 16'h0000);
      addVec("wr_r4_high",   1, 4'd4, 2'b10, 16'hABCD, 4'd7, 4'd5, 16'hCDAB, 16'hA5C3);
      addVec("rd_r4_high",   0, 4'd0, 2'b00, 16'h0000, 4'd4, 4'd7, 16'hCD00, 16'hCDAB);
      addVec("wr_r4_low",    1, 4'd4, 2'b01, 16'h1234, 4'd5, 4'd7, 16'hA5C3, 16'hCDAB);
      addVec("rd_r4_low",    0, 4'd0, 2'b00, 16'h0000, 4'd4, 4'd0, 16'hCD34, 16'h0000);
      addVec("no_wr_en",     0, 4'd4, 2'b00, 16'hFFFF, 4'd4, 4'd5, 16'hCD34, 16'hA5C3);
      addVec("rd_r4_no_wr",  0, 4'd0, 2'b00, 16'h0000, 4'd4, 4'd4, 16'hCD34, 16'hCD34);

      // Initial reset so the array starts from known zeros.
      applyStimulus(1, 0, 4'd0, 2'b00, 16'h0000, 4'd0, 4'd0);
      tick();

      // Reset test: preload R1..R15 with all ones, then one reset cycle.
      for (int i = 1; i < 16; i++) begin
         applyStimulus(0, 1, 4'(i), 2'b00, 16'hFFFF, 4'd0, 4'd0);
         tick();
      end
      applyStimulus(0, 0, 4'd0, 2'b00, 16'h0000, 4'd1, 4'd15);
      checkOutput("preload_r1", SrcData1, 16'hFFFF);
      checkOutput("preload_r15", SrcData2, 16'hFFFF);
      applyStimulus(1, 0, 4'd0, 2'b00, 16'h0000, 4'd8, 4'd0);
      checkOutput("read_during_rst", SrcData1, 16'hFFFF);
      tick();
      for (int i = 1; i < 16; i++) begin
         applyStimulus(0, 0, 4'd0, 2'b00, 16'h0000, 4'(i), 4'(16 - i));
         checkOutput($sformatf("rst_clear_p1_r%0d", i), SrcData1, 16'h0000);
         checkOutput($sformatf("rst_clear_p2_r%0d", 16 - i), SrcData2, 16'h0000);
      end

      // Table-driven main function.
      foreach (vecs[k]) begin
         applyStimulus(0, vecs[k].wr, vecs[k].dst, vecs[k].mode, vecs[k].data,
                       vecs[k].s1, vecs[k].s2);
         checkOutput({vecs[k].name, "_p1"}, SrcData1, vecs[k].e1);
         checkOutput({vecs[k].name, "_p2"}, SrcData2, vecs[k].e2);
         tick();
      end

      // Same-cycle write and read of R3 (full, then low byte).
`ifdef RF_BYPASS_EN
      exp_bypass    = 16'h7F00;
      exp_bypass_lo = 16'h7F55;
`else
      exp_bypass    = 16'h0001;
      exp_bypass_lo = 16'h7F00;
`endif
      applyStimulus(0, 1, 4'd3, 2'b00, 16'h0001, 4'd0, 4'd0);
      tick();
      applyStimulus(0, 1, 4'd3, 2'b00, 16'h7F00, 4'd3, 4'd3);
      checkOutput("bypass_full_p2", SrcData2, exp_bypass);
      checkOutput("bypass_full_p1", SrcData1, exp_bypass);
      tick();
      applyStimulus(0, 0, 4'd0, 2'b00, 16'h0000, 4'd3, 4'd3);
      checkOutput("after_bypass_full", SrcData2, 16'h7F00);
      applyStimulus(0, 1, 4'd3, 2'b01, 16'h0055, 4'd3, 4'd0);
      checkOutput("bypass_low_p1", SrcData1, exp_bypass_lo);
      tick();
      applyStimulus(0, 0, 4'd0, 2'b00, 16'h0000, 4'd3, 4'd0);
      checkOutput("after_bypass_low", SrcData1, 16'h7F55);
      tick();

      // Reset versus write in the same cycle on R9.
      applyStimulus(0, 1, 4'd9, 2'b00, 16'h1111, 4'd0, 4'd0);
      tick();
      applyStimulus(1, 1, 4'd9, 2'b00, 16'hBEEF, 4'd9, 4'd0);
      checkOutput("rst_wr_pre_edge", SrcData1, 16'h1111);
      tick();
      applyStimulus(0, 0, 4'd0, 2'b00, 16'h0000, 4'd9, 4'd3);
      checkOutput("rst_wr_r9", SrcData1, 16'h0000);
      checkOutput("rst_wr_r3", SrcData2, 16'h0000);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
      $finish;
   end

endmodule
